// File: rtl/bcd_convert_sched_pkg.sv
// Shared types and helpers for the time-shared binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int DIG_W = 4;

  typedef struct packed {
    logic hit;
    logic id;
  } grant_t;

  function automatic logic [DIG_W-1:0] add3_adj(input logic [DIG_W-1:0] digit);
    return (digit >= DIG_W'(5)) ? digit + DIG_W'(3) : digit;
  endfunction

endpackage

// File: rtl/bcd_convert_sched_if.sv
// Request/result bundle between the two requesters, the converter and the display side.
interface bcd_convert_sched_if #(
  parameter int BIN_W = 8,
  parameter int NDIG  = 3
);
  import bcd_pkg::*;

  logic                  req0_valid;
  logic [BIN_W-1:0]      req0_bin;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [BIN_W-1:0]      req1_bin;
  logic                  req1_ready;
  logic                  res_valid;
  logic                  res_ready;
  logic [DIG_W*NDIG-1:0] res_bcd;
  logic                  res_id;
  logic                  busy;

  modport master (
    output req0_valid, req0_bin, req1_valid, req1_bin, res_ready,
    input  req0_ready, req1_ready, res_valid, res_bcd, res_id, busy
  );

  modport slave (
    input  req0_valid, req0_bin, req1_valid, req1_bin, res_ready,
    output req0_ready, req1_ready, res_valid, res_bcd, res_id, busy
  );

endinterface

// File: rtl/bcd_convert_sched_digit_cell.sv
// One BCD digit of the double-dabble chain: add-3 correction, then shift left by one.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             din_lsb,
  output logic             dout_msb,
  output logic [DIG_W-1:0] digit
);

  logic [DIG_W-1:0] digit_q, digit_d, adj;

  always_comb begin
    adj     = add3_adj(digit_q);
    digit_d = digit_q;
    if (clear)         digit_d = '0;
    else if (shift_en) digit_d = {adj[DIG_W-2:0], din_lsb};
  end

  // Carry into the next digit comes from the corrected value, not the stored one.
  assign dout_msb = adj[DIG_W-1];
  assign digit    = digit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) digit_q <= '0;
    else        digit_q <= digit_d;
  end

endmodule

// File: rtl/bcd_convert_sched.sv
// Round-robin shared serial double-dabble converter: two requesters, one result port.
module bcd_convert_sched
  import bcd_pkg::*;
#(
  parameter int BIN_W = 8,
  parameter int NDIG  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_convert_sched_if.slave  bus
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t                        state_q, state_d;
  logic [BIN_W-1:0]              sreg_q, sreg_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          res_id_q, res_id_d;
  logic                          last_q, last_d;
  logic                          clear, shift_en;
  grant_t                        gnt;
  logic [NDIG:0]                 chain;
  logic [NDIG-1:0][DIG_W-1:0]    dig;

  // Tie goes to whichever requester did not win last time.
  always_comb begin
    gnt.hit = bus.req0_valid | bus.req1_valid;
    gnt.id  = (bus.req0_valid & bus.req1_valid) ? ~last_q : bus.req1_valid;
  end

  assign bus.req0_ready = (state_q == IDLE) & bus.req0_valid & ~gnt.id;
  assign bus.req1_ready = (state_q == IDLE) & bus.req1_valid &  gnt.id;

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    res_id_d = res_id_q;
    last_d   = last_q;
    clear    = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt.hit) begin
          sreg_d   = gnt.id ? bus.req1_bin : bus.req0_bin;
          cnt_d    = CNT_W'(BIN_W);
          res_id_d = gnt.id;
          last_d   = gnt.id;
          clear    = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        // Top digit's carry refills sreg; it is always 0 when NDIG is sized correctly.
        sreg_d   = {sreg_q[BIN_W-2:0], chain[NDIG]};
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign chain[0] = sreg_q[BIN_W-1];

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    bcd_digit_cell u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .shift_en (shift_en),
      .din_lsb  (chain[i]),
      .dout_msb (chain[i+1]),
      .digit    (dig[i])
    );
  end

  assign bus.res_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.res_id    = res_id_q;
  assign bus.res_bcd   = dig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      cnt_q    <= '0;
      res_id_q <= 1'b0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      cnt_q    <= cnt_d;
      res_id_q <= res_id_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: tb/tb_bcd_convert_sched.sv
// Directed and randomized checks of the shared BCD converter against a divide/mod model.
module tb_bcd_convert_sched;

  localparam int BIN_W = 8;
  localparam int NDIG  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  bcd_convert_sched_if #(.BIN_W(BIN_W), .NDIG(NDIG)) bus ();

  bcd_convert_sched #(.BIN_W(BIN_W), .NDIG(NDIG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic vld, input logic [7:0] v);
    if (p == 0) begin bus.req0_valid = vld; bus.req0_bin = v; end
    else        begin bus.req1_valid = vld; bus.req1_bin = v; end
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req0_valid = 0; bus.req0_bin = '0;
    bus.req1_valid = 0; bus.req1_bin = '0;
    bus.res_ready  = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_rdy(input int p);
    int n = 0;
    #1;
    while (!rdy(p) && n < 40) begin tick(); n++; end
    chk("ready_timeout", 32'(n < 40), 1);
  endtask

  task automatic wait_res(input bit rnd);
    int k = 0;
    if (rnd) bus.res_ready = 1'($urandom_range(0, 1));
    #1;
    while (!(bus.res_valid && bus.res_ready) && k < 60) begin
      tick();
      if (rnd) bus.res_ready = 1'($urandom_range(0, 1));
      #1;
      k++;
    end
    chk("result_timeout", 32'(k < 60), 1);
  endtask

  task automatic chk_res(input string tag, input int v, input int id);
    chk({tag, "_bcd"}, 32'(bus.res_bcd), 32'(ref_bcd(v)));
    chk({tag, "_id"}, 32'(bus.res_id), 32'(id));
    for (int d = 0; d < NDIG; d++)
      chk({tag, "_digit_le9"}, 32'(bus.res_bcd[4*d +: 4] <= 4'd9), 1);
  endtask

  task automatic xact(input int p, input int v, input bit rnd);
    set_req(p, 1'b1, 8'(v));
    wait_rdy(p);
    tick();
    set_req(p, 1'b0, 8'(v));
    wait_res(rnd);
    chk_res("conv", v, p);
    tick();
    chk("consumed", 32'(bus.res_valid), 0);
  endtask

  initial begin
    int k, exp_g, got;
    logic [7:0] b0, b1, v;
    logic [11:0] hold_bcd;
    logic hold_id;

    // Reset state
    rst_n = 1'b0;
    bus.req0_valid = 0; bus.req0_bin = '0;
    bus.req1_valid = 0; bus.req1_bin = '0;
    bus.res_ready  = 0;
    repeat (3) tick();
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_res_bcd",   32'(bus.res_bcd), 0);
    chk("rst_res_id",    32'(bus.res_id), 0);
    chk("rst_busy",      32'(bus.busy), 0);
    rst_n = 1'b1;
    tick();

    // 255 on req0, latency and busy release
    bus.res_ready = 1;
    set_req(0, 1'b1, 8'd255);
    #1;
    chk("t1_r0_ready", 32'(bus.req0_ready), 1);
    chk("t1_r1_ready", 32'(bus.req1_ready), 0);
    tick();
    set_req(0, 1'b0, 8'd0);
    chk("t1_busy", 32'(bus.busy), 1);
    repeat (7) tick();
    chk("t1_not_yet", 32'(bus.res_valid), 0);
    tick();
    chk("t1_valid", 32'(bus.res_valid), 1);
    chk_res("t1", 255, 0);
    tick();
    chk("t1_consumed", 32'(bus.res_valid), 0);
    chk("t1_busy_low", 32'(bus.busy), 0);

    // Both valid from reset: req0 first, req1 blocked until IDLE
    do_reset();
    bus.res_ready = 1;
    set_req(0, 1'b1, 8'd42);
    set_req(1, 1'b1, 8'd99);
    #1;
    chk("t2_r0_ready", 32'(bus.req0_ready), 1);
    chk("t2_r1_ready", 32'(bus.req1_ready), 0);
    tick();
    set_req(0, 1'b0, 8'd0);
    #1;
    k = 0;
    while (!bus.res_valid && k < 20) begin
      chk("t2_r1_blocked", 32'(bus.req1_ready), 0);
      tick(); k++;
    end
    chk("t2_timeout", 32'(k < 20), 1);
    chk("t2_r1_blocked_done", 32'(bus.req1_ready), 0);
    chk_res("t2a", 42, 0);
    tick();
    chk("t2_r1_ready", 32'(bus.req1_ready), 1);
    tick();
    set_req(1, 1'b0, 8'd0);
    wait_res(0);
    chk_res("t2b", 99, 1);
    tick();

    // Both held valid: grants alternate starting with req0
    exp_g = 0;
    b0 = 8'($urandom_range(0, 255));
    b1 = 8'($urandom_range(0, 255));
    set_req(0, 1'b1, b0);
    set_req(1, 1'b1, b1);
    for (int i = 0; i < 4; i++) begin
      k = 0;
      #1;
      while (!(bus.req0_ready || bus.req1_ready) && k < 40) begin tick(); k++; end
      chk("t3_timeout", 32'(k < 40), 1);
      got = bus.req1_ready ? 1 : 0;
      chk("t3_grant", 32'(got), 32'(exp_g));
      v = got ? b1 : b0;
      tick();
      if (got == 1) begin b1 = 8'($urandom_range(0, 255)); set_req(1, 1'b1, b1); end
      else          begin b0 = 8'($urandom_range(0, 255)); set_req(0, 1'b1, b0); end
      wait_res(0);
      chk_res("t3", int'(v), exp_g);
      tick();
      exp_g ^= 1;
    end
    set_req(0, 1'b0, 8'd0);
    set_req(1, 1'b0, 8'd0);

    // Stall in DONE: outputs held, no ready given
    bus.res_ready = 0;
    v = 8'($urandom_range(0, 255));
    set_req(0, 1'b1, v);
    wait_rdy(0);
    tick();
    set_req(0, 1'b0, 8'd0);
    set_req(1, 1'b1, 8'd5);
    k = 0;
    while (!bus.res_valid && k < 20) begin tick(); k++; end
    chk("t4_timeout", 32'(k < 20), 1);
    hold_bcd = bus.res_bcd;
    hold_id  = bus.res_id;
    chk_res("t4", int'(v), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_valid_held", 32'(bus.res_valid), 1);
      chk("t4_bcd_held",   32'(bus.res_bcd), 32'(hold_bcd));
      chk("t4_id_held",    32'(bus.res_id), 32'(hold_id));
      chk("t4_no_r0",      32'(bus.req0_ready), 0);
      chk("t4_no_r1",      32'(bus.req1_ready), 0);
    end
    bus.res_ready = 1;
    set_req(1, 1'b0, 8'd0);
    tick();
    chk("t4_released", 32'(bus.res_valid), 0);

    // Reset mid-SHIFT discards the conversion
    set_req(0, 1'b1, 8'd128);
    wait_rdy(0);
    tick();
    set_req(0, 1'b0, 8'd0);
    repeat (3) tick();
    chk("t5_in_shift", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_busy",      32'(bus.busy), 0);
    chk("t5_res_valid", 32'(bus.res_valid), 0);
    chk("t5_res_bcd",   32'(bus.res_bcd), 0);
    chk("t5_res_id",    32'(bus.res_id), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    xact(1, 7, 0);

    // Every value through both ports with random back-pressure
    for (int val = 0; val < 256; val++) begin
      xact(0, val, 1);
      xact(1, val, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
